// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST sequencer.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SETTLE = 1;

  // Expected adder result: the carry out is discarded, so the sum wraps.
  function automatic int unsigned mod_sum(int unsigned a, int unsigned b, int width);
    int unsigned mask;
    mask = (32'd1 << width) - 32'd1;
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/result bus between the BIST sequencer (master) and the adder under test (slave).
interface adder_bist_if
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] sum_in;

  modport master (output a_out, output b_out, input sum_in);
  modport slave  (input a_out, input b_out, output sum_in);
endinterface

// File: rtl/adder_bist_operand_sweep.sv
// Nested operand counter: j is the inner index, i advances when j wraps.
module operand_sweep
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] j,
  output logic             last
);

  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH-1:0] j_q, j_d;

  // Next operand pair: clear wins over advance; i steps only on j wrap.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear) begin
      i_d = '0;
      j_d = '0;
    end else if (advance) begin
      j_d = j_q + 1'b1;
      if (j_q == '1) begin
        i_d = i_q + 1'b1;
      end
    end
  end

  // Operand registers drive the adder directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign last = (i_q == '1) && (j_q == '1);

endmodule

// File: rtl/adder_bist.sv
// Exhaustive on-chip check of a WIDTH-bit adder: sweeps all operand pairs,
// waits SETTLE cycles per pair, compares the modular sum and logs failures.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  adder_bist_if.master       bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [WIDTH-1:0]   fail_sum
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  // All-fail count (2^(2*WIDTH)) is also the saturation ceiling.
  localparam logic [2*WIDTH:0] ERR_MAX  = {1'b1, {(2*WIDTH){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] err_q, err_d, err_next;
  logic             pass_q, pass_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic [WIDTH-1:0] fs_q, fs_d;

  logic             sweep_clear;
  logic             sweep_adv;
  logic [WIDTH-1:0] op_i;
  logic [WIDTH-1:0] op_j;
  logic             op_last;
  logic             mismatch;

  operand_sweep #(.WIDTH(WIDTH)) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .clear   (sweep_clear),
    .advance (sweep_adv),
    .i       (op_i),
    .j       (op_j),
    .last    (op_last)
  );

  assign mismatch = (bus.sum_in != WIDTH'(mod_sum(32'(op_i), 32'(op_j), WIDTH)));

  // Sequencer next-state and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_next    = err_q;
    pass_d      = pass_q;
    fv_d        = fv_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    fs_d        = fs_q;
    sweep_clear = 1'b0;
    sweep_adv   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_SETTLE;
          cnt_d       = CNT_LOAD;
          err_d       = '0;
          pass_d      = 1'b0;
          fv_d        = 1'b0;
          fa_d        = '0;
          fb_d        = '0;
          fs_d        = '0;
          sweep_clear = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_next = err_q + 1'b1;
          end
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = op_i;
            fb_d = op_j;
            fs_d = bus.sum_in;
          end
        end
        err_d = err_next;
        if (op_last) begin
          // The final pair's result is folded into pass on the same edge.
          state_d = ST_DONE;
          pass_d  = (err_next == '0);
        end else begin
          state_d   = ST_SETTLE;
          cnt_d     = CNT_LOAD;
          sweep_adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset clears everything, aborting any sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.a_out  = op_i;
  assign bus.b_out  = op_j;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_sum   = fs_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two instances (SETTLE=1 and SETTLE=3) each drive a
// behavioural adder with selectable faults; results are compared against a
// pair-by-pair reference computed with plain arithmetic.
module tb_adder_bist;
  import adder_bist_pkg::*;

  localparam int W      = 4;
  localparam int NPAIRS = 1 << (2 * W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  logic busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [2*W:0] err1, err3;
  logic [W-1:0] fa1, fb1, fs1, fa3, fb3, fs3;

  adder_bist_if #(.WIDTH(W)) bus1 ();
  adder_bist_if #(.WIDTH(W)) bus3 ();

  adder_bist #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_sum(fs1)
  );

  adder_bist #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bus(bus3.master),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3), .fail_sum(fs3)
  );

  // Fault configuration: 0 good, 1 stuck bit, 2 one bad pair, 3 two-register lag, 4 inverted.
  int mode1 = 0;
  int mode3 = 0;
  int sb = 0;
  int sv = 0;
  int bad_a = 0;
  int bad_b = 0;
  int xmask = 1;

  function automatic logic [W-1:0] faulty(int mode, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
    case (mode)
      1: s[sb] = sv[0];
      2: if (int'(a) == bad_a && int'(b) == bad_b) s = s ^ W'(xmask);
      4: s = ~s;
      default: ;
    endcase
    return s;
  endfunction

  logic [W-1:0] lag1_a = '0, lag1_b = '0, lag3_a = '0, lag3_b = '0;
  always @(posedge clk) begin
    lag1_a <= bus1.a_out + bus1.b_out;
    lag1_b <= lag1_a;
    lag3_a <= bus3.a_out + bus3.b_out;
    lag3_b <= lag3_a;
  end

  assign bus1.sum_in = (mode1 == 3) ? lag1_b : faulty(mode1, bus1.a_out, bus1.b_out);
  assign bus3.sum_in = (mode3 == 3) ? lag3_b : faulty(mode3, bus3.a_out, bus3.b_out);

  // Observation mux so one sweep task serves both instances.
  bit sel = 1'b0;
  logic o_busy, o_done, o_pass, o_fv;
  logic [2*W:0] o_err;
  logic [W-1:0] o_a, o_b, o_fa, o_fb, o_fs;
  assign o_busy = sel ? busy3 : busy1;
  assign o_done = sel ? done3 : done1;
  assign o_pass = sel ? pass3 : pass1;
  assign o_fv   = sel ? fv3 : fv1;
  assign o_err  = sel ? err3 : err1;
  assign o_a    = sel ? bus3.a_out : bus1.a_out;
  assign o_b    = sel ? bus3.b_out : bus1.b_out;
  assign o_fa   = sel ? fa3 : fa1;
  assign o_fb   = sel ? fb3 : fb1;
  assign o_fs   = sel ? fs3 : fs1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk every pair, decide what the adder shows at the sample
  // point, and tally mismatches against the wrapped sum.
  task automatic model(input int mode, input int s, output int e_err, output bit e_fv,
                       output int e_fa, output int e_fb, output int e_fs);
    int i, j, expv, obs, vis;
    e_err = 0; e_fv = 1'b0; e_fa = 0; e_fb = 0; e_fs = 0;
    for (int n = 0; n < NPAIRS; n++) begin
      i = n / (1 << W);
      j = n % (1 << W);
      expv = (i + j) % (1 << W);
      if (mode == 3) begin
        // A two-stage lag shows the current pair only if it was applied >= 2 cycles before sampling.
        vis = (s >= 2) ? n : n - 1;
        obs = (vis < 0) ? 0 : ((vis / (1 << W)) + (vis % (1 << W))) % (1 << W);
      end else begin
        obs = int'(faulty(mode, W'(i), W'(j)));
      end
      if (obs != expv) begin
        if (e_err < NPAIRS) e_err++;
        if (!e_fv) begin
          e_fv = 1'b1; e_fa = i; e_fb = j; e_fs = obs;
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_sweep(input bit which, input int mode, input int s, input bit hold);
    int e_err, e_fa, e_fb, e_fs, total, cyc;
    bit e_fv;
    sel = which;
    if (which) mode3 = mode; else mode1 = mode;
    model(mode, s, e_err, e_fv, e_fa, e_fb, e_fs);
    total = NPAIRS * (s + 1);
    if (which) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    check_eq("start_busy", 32'(o_busy), 1);
    check_eq("start_done_clr", 32'(o_done), 0);
    check_eq("start_err_clr", 32'(o_err), 0);
    check_eq("start_fv_clr", 32'(o_fv), 0);
    if (!hold) begin
      start1 = 1'b0; start3 = 1'b0;
    end
    cyc = 0;
    while (!o_done && cyc <= total + 8) begin
      check_eq("pair", 32'({o_a, o_b}), 32'((cyc / (s + 1)) % NPAIRS));
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("done_latency", 32'(cyc), 32'(total));
    check_eq("done_busy", 32'(o_busy), 0);
    check_eq("pass", 32'(o_pass), 32'(e_err == 0));
    check_eq("err_count", 32'(o_err), 32'(e_err));
    check_eq("fail_valid", 32'(o_fv), 32'(e_fv));
    check_eq("fail_a", 32'(o_fa), 32'(e_fa));
    check_eq("fail_b", 32'(o_fb), 32'(e_fb));
    check_eq("fail_sum", 32'(o_fs), 32'(e_fs));
    start1 = 1'b0; start3 = 1'b0;
  endtask

  initial begin
    do_reset(3);
    // Reset state of both instances.
    check_eq("rst_busy", 32'(busy1), 0);
    check_eq("rst_done", 32'(done1), 0);
    check_eq("rst_pass", 32'(pass1), 0);
    check_eq("rst_fv", 32'(fv1), 0);
    check_eq("rst_err", 32'(err1), 0);
    check_eq("rst_ab", 32'({bus1.a_out, bus1.b_out}), 0);
    check_eq("rst_fail", 32'({fa1, fb1, fs1}), 0);
    check_eq("rst3_state", 32'({busy3, done3, pass3, fv3}), 0);

    // Good adder; wrap pairs such as (15,15)->14 and (15,1)->0 must not be flagged.
    run_sweep(0, 0, 1, 0);

    // Sum bit 0 stuck at 0.
    sb = 0; sv = 0;
    run_sweep(0, 1, 1, 0);
    check_eq("stuck0_count", 32'(err1), 128);

    // Restart from DONE with a good adder clears the previous failures.
    run_sweep(0, 0, 1, 0);

    // Randomized faults.
    for (int t = 0; t < 3; t++) begin
      sb    = int'($urandom_range(0, W - 1));
      sv    = int'($urandom_range(0, 1));
      bad_a = int'($urandom_range(0, (1 << W) - 1));
      bad_b = int'($urandom_range(0, (1 << W) - 1));
      xmask = int'($urandom_range(1, (1 << W) - 1));
      run_sweep(0, ($urandom_range(0, 1) == 0) ? 1 : 2, 1, 0);
    end

    // Every pair wrong: count reaches the all-fail value without wrapping.
    run_sweep(0, 4, 1, 0);

    // Start held high for the whole sweep does not restart it.
    sb = 0; sv = 0;
    run_sweep(0, 1, 1, 1);
    @(posedge clk); #1;
    check_eq("done_hold", 32'(done1), 1);
    check_eq("done_frozen_ab", 32'({bus1.a_out, bus1.b_out}), 32'(NPAIRS - 1));
    check_eq("done_frozen_err", 32'(err1), 128);

    // Reset in the middle of a sweep.
    sel = 1'b0; mode1 = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy", 32'(busy1), 0);
    check_eq("abort_a", 32'(bus1.a_out), 0);
    check_eq("abort_err", 32'(err1), 0);
    check_eq("abort_fv", 32'(fv1), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep(0, 1, 1, 0);

    // Lagging adder: enough settle time on SETTLE=3, too little on SETTLE=1.
    do_reset(3);
    run_sweep(1, 3, 3, 0);
    check_eq("lag_s3_pass", 32'(pass3), 1);
    mode1 = 3;
    do_reset(3);
    run_sweep(0, 3, 1, 0);
    check_eq("lag_s1_pass", 32'(pass1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_bist.md
# adder_bist

Self-checking operand sequencer that sits directly upstream of the 4-bit `adder` and also consumes its result. On `start` it sweeps every (a, b) operand pair in nested order, drives each pair onto the adder inputs, waits a settle interval, and compares `sum` against the modular expected value. It counts mismatches and captures the first failing vector, replacing the simulation-only exhaustive loop with a synthesizable on-chip check.

## Interface
- `WIDTH`, default 4: operand and sum width; the sweep covers 2^(2·WIDTH) pairs.
- `SETTLE`, default 1: cycles (≥1) between applying a pair and sampling `sum_in`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE or DONE.
- `a_out` out WIDTH: operand a to the adder (registered).
- `b_out` out WIDTH: operand b to the adder (registered).
- `sum_in` in WIDTH: adder result.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep finished; held until the next start or reset.
- `pass` out 1: valid when `done`=1; 1 iff `err_count`=0.
- `err_count` out 2·WIDTH+1: mismatch count, saturating at 2^(2·WIDTH).
- `fail_valid` out 1: a first-failure vector has been captured.
- `fail_a`, `fail_b`, `fail_sum` out WIDTH each: operands and observed sum of the first mismatch.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: `start`=1 → load i=j=0, `a_out`=`b_out`=0, clear `err_count`, `fail_*`, `pass`, `done`; settle counter = SETTLE−1; go to SETTLE.
- SETTLE: counter=0 → CHECK, else decrement.
- CHECK, single cycle:
  - Expected = (i + j) mod 2^WIDTH; the carry is discarded, so a=15, b=15 expects 14.
  - On mismatch, increment `err_count`. If `fail_valid`=0, capture i, j, `sum_in` and set `fail_valid`.
  - Advance j. When j wraps from max to 0, advance i.
  - Pair (max, max) → DONE with `pass` = (final count = 0).
  - Otherwise drive the next pair onto `a_out`/`b_out`, reload the settle counter, return to SETTLE.
- DONE: `done`=1, outputs frozen. `start`=1 restarts exactly as from IDLE.
- `start` is ignored in SETTLE/CHECK; holding it high does not restart a sweep.
- `busy`=1 in SETTLE and CHECK only.

## Timing
- Reset values:
  - State IDLE.
  - `a_out`=`b_out`=0.
  - `busy`=`done`=`pass`=`fail_valid`=0.
  - `err_count`=0 and `fail_a`=`fail_b`=`fail_sum`=0.
- Reset has priority over `start` and aborts a sweep mid-run; all outputs return to reset values on the next edge.
- Start accepted at edge k: `busy`=1 and pair (0,0) valid on `a_out`/`b_out` after edge k.
- Each pair is held for SETTLE+1 cycles. `sum_in` is sampled at the CHECK edge only.
- `done` rises at edge k + 2^(2·WIDTH)·(SETTLE+1); that is 512 cycles for the defaults. `busy` falls on the same edge.
- The final pair's mismatch is included in `err_count` and `pass` on the edge where `done` rises.
- Saturation: `err_count` never wraps; width 2·WIDTH+1 holds the all-fail count of 256.

## Structure
- Package `adder_bist_pkg`: state enum, default WIDTH/SETTLE constants, and a function computing the modular expected sum.
- Sub-module `operand_sweep`: nested i/j counter with `clear`, `advance` and a `last` flag; `adder_bist` instantiates it.
- The `adder` under test is not instantiated inside `adder_bist`; the bench or top level wires `a_out`/`b_out`/`sum_in` to it.

## Test plan
- Correct `adder`, defaults, start pulse → `busy`=1 for 512 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- Adder with sum bit 0 stuck at 0 → `err_count`=128, `fail_valid`=1, `fail_a`=0, `fail_b`=1, `fail_sum`=0, `pass`=0.
- Wrap case with a correct adder: pair (15,15) samples 14 and is not flagged; (15,1) samples 0 and is not flagged.
- `rst` asserted at cycle 100 of a sweep → next edge: `busy`=0, `a_out`=0, `err_count`=0. A new start then takes the full 512 cycles.
- `start` held high throughout the sweep → no restart, `done` still at 512 cycles. A start pulse in DONE clears `done` and `err_count` on the next edge and reruns.
- SETTLE=3 with an adder whose output lags by 2 registers → `pass`=1 after 1024 cycles. The same adder with SETTLE=1 → `pass`=0.
